mips_avalon_arbiter: RTL and testbench

//  N-master to 1-slave Avalon-MM arbiter between CPU-side masters and the shared mips_avalon_slave memory.

---
 rtl/mips_avalon_pkg.sv | 18 +
 rtl/mips_arb_pick.sv | 33 +++
 rtl/mips_avalon_arbiter.sv | 143 ++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the N-master Avalon-MM arbiter.
package mips_avalon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED        = 0;
  localparam int ARB_RR           = 1;
  localparam int TIMEOUT_READDATA = 0;

  // Index width that stays at least one bit for a single-master build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round robin from ptr+1.
module mips_arb_pick
  import mips_avalon_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = ARB_FIXED,
  localparam int GW  = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] win,
  output logic          any
);

  logic [GW-1:0] fx_win, rr_win;

  always_comb begin
    fx_win = '0;
    rr_win = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fx_win = GW'(i);
    end
    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (((int'(ptr) + k) % N) == i)) rr_win = GW'(i);
      end
    end
    win = (MODE == ARB_RR) ? rr_win : fx_win;
  end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// N-master to 1-slave Avalon-MM arbiter with watchdog and sticky protocol/timeout flags.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 10000,
  localparam int BE_W          = DATA_W / 8,
  localparam int GW            = idx_w(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*BE_W-1:0]     m_byteenable,
  input  logic [N_MASTERS-1:0]          m_read,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [N_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [ADDR_W-1:0]             s_address,
  output logic [BE_W-1:0]               s_byteenable,
  output logic                          s_read,
  output logic                          s_write,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          proto_err,
  output logic                          timeout_err
);

  localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_t      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_win;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            proto_err_q, proto_err_d, timeout_err_q, timeout_err_d;
  logic            pick_any, g_rd, g_wr, wd_fire;

  logic [ADDR_W-1:0] addr_a  [N_MASTERS];
  logic [BE_W-1:0]   be_a    [N_MASTERS];
  logic [DATA_W-1:0] wdata_a [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign addr_a[i]  = m_address[i*ADDR_W +: ADDR_W];
    assign be_a[i]    = m_byteenable[i*BE_W +: BE_W];
    assign wdata_a[i] = m_writedata[i*DATA_W +: DATA_W];
  end

  mips_arb_pick #(.N(N_MASTERS), .MODE(ARB_MODE)) u_pick (
    .req (m_read | m_write),
    .ptr (rr_ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = '0;
    proto_err_d   = proto_err_q;
    timeout_err_d = timeout_err_q;
    g_rd          = m_read[grant_q];
    g_wr          = m_write[grant_q];
    wd_fire       = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_W'(TO_LAST));
    s_address     = addr_a[grant_q];
    s_byteenable  = be_a[grant_q];
    s_writedata   = wdata_a[grant_q];
    s_read        = 1'b0;
    s_write       = 1'b0;
    m_waitrequest = '1;
    m_readdata    = s_readdata;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (!g_rd && !g_wr) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (wd_fire) begin
          timeout_err_d          = 1'b1;
          m_waitrequest[grant_q] = 1'b0;
          m_readdata             = DATA_W'(TIMEOUT_READDATA);
          state_d                = IDLE;
        end else begin
          // Read+write together is served as a write and flagged.
          s_write = g_wr;
          s_read  = g_rd & ~g_wr;
          if (g_rd && g_wr) proto_err_d = 1'b1;
          if (!s_waitrequest) begin
            m_waitrequest[grant_q] = 1'b0;
            state_d                = IDLE;
          end
        end
        if (state_d == IDLE) begin
          wd_cnt_d = '0;
          if (ARB_MODE == ARB_RR) rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // The slave must never see a strobe while reset is held, even mid-transfer.
    if (reset) begin
      s_read        = 1'b0;
      s_write       = 1'b0;
      m_waitrequest = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= GW'(N_MASTERS - 1);
      wd_cnt_q      <= '0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant_id    = grant_q;
  assign proto_err   = proto_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share master stimulus; one is checked per test.
module tb_mips_avalon_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  typedef struct { int m; logic rd; logic [DW-1:0] rdata; } cpl_t;
  typedef struct { logic [AW-1:0] a; logic [BW-1:0] be; logic [DW-1:0] d; } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byteenable;
  logic [N-1:0]    m_read, m_write;
  logic [N*DW-1:0] m_writedata;

  logic [1:0][N-1:0]  m_wait_v;
  logic [1:0][DW-1:0] m_rdata_v, s_wdata_v;
  logic [1:0][AW-1:0] s_addr_v;
  logic [1:0][BW-1:0] s_be_v;
  logic [1:0]         s_rd_v, s_wr_v, s_wait_v, gid_v, perr_v, terr_v;

  int          rd_delay = 0;
  logic        stall = 1'b0;
  logic [DW-1:0] sl_data = '0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    int scnt = 0;
    mips_avalon_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                          .ARB_MODE(d), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .m_address     (m_address),
      .m_byteenable  (m_byteenable),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_wait_v[d]),
      .m_readdata    (m_rdata_v[d]),
      .s_address     (s_addr_v[d]),
      .s_byteenable  (s_be_v[d]),
      .s_read        (s_rd_v[d]),
      .s_write       (s_wr_v[d]),
      .s_writedata   (s_wdata_v[d]),
      .s_waitrequest (s_wait_v[d]),
      .s_readdata    (sl_data),
      .grant_id      (gid_v[d]),
      .proto_err     (perr_v[d]),
      .timeout_err   (terr_v[d])
    );
    // Slave accepts after rd_delay stalled cycles unless told to stall forever.
    assign s_wait_v[d] = stall || !((s_rd_v[d] || s_wr_v[d]) && (scnt >= rd_delay));
    always @(posedge clk) begin
      if ((s_rd_v[d] || s_wr_v[d]) && s_wait_v[d]) scnt <= scnt + 1;
      else scnt <= 0;
    end
  end

  cpl_t exp_q[$];
  wr_t  wr_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cur = 0, cyc = 0;
  logic [N-1:0] done = '0;
  int   cont[N], issue_cyc[N], last_lat[N], wlow[N];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic monitor();
    cpl_t e;
    wr_t  w;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!m_wait_v[cur][i]) wlow[i]++;
      if (!m_wait_v[cur][i] && (m_read[i] || m_write[i])) begin
        done[i]     = 1'b1;
        last_lat[i] = cyc - issue_cyc[i];
        if (exp_q.size() == 0) chk("unexp_cpl", 64'(m_wait_v[cur][i]), 1);
        else begin
          e = exp_q.pop_front();
          chk("cpl_master", i, e.m);
          chk("grant_id", 64'(gid_v[cur]), e.m);
          if (e.rd) chk("readdata", 64'(m_rdata_v[cur]), 64'(e.rdata));
        end
      end
    end
    if (s_wr_v[cur] && !s_wait_v[cur]) begin
      if (wr_q.size() == 0) chk("unexp_wr", 64'(s_wr_v[cur]), 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(s_addr_v[cur]), 64'(w.a));
        chk("wr_be", 64'(s_be_v[cur]), 64'(w.be));
        chk("wr_data", 64'(s_wdata_v[cur]), 64'(w.d));
      end
    end
    if (reset) chk("rst_strobe", 64'({s_rd_v[cur], s_wr_v[cur]}), 0);
  endtask

  task automatic service();
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        done[i] = 1'b0;
        if (cont[i] > 0) begin
          cont[i]--;
          issue_cyc[i] = cyc;
        end else begin
          m_read[i]  = 1'b0;
          m_write[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    service();
  endtask

  task automatic issue(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    m_read[m]               = rd;
    m_write[m]              = wr;
    m_address[m*AW +: AW]   = a;
    m_byteenable[m*BW +: BW] = be;
    m_writedata[m*DW +: DW] = d;
    issue_cyc[m]            = cyc;
  endtask

  task automatic push_cpl(input int m, input logic rd, input logic [DW-1:0] rdata);
    cpl_t e;
    e.m = m; e.rd = rd; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    wr_t w;
    w.a = a; w.be = be; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || wr_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_cpl_left"}, exp_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    m_read   = '0;
    m_write  = '0;
    done     = '0;
    stall    = 1'b0;
    rd_delay = 0;
    for (int i = 0; i < N; i++) begin
      cont[i] = 0;
      wlow[i] = 0;
    end
    exp_q.delete();
    wr_q.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag, input int d);
    chk({tag, "_mwait"}, 64'(m_wait_v[d]), 64'(2'b11));
    chk({tag, "_sstrb"}, 64'({s_rd_v[d], s_wr_v[d]}), 0);
    chk({tag, "_gid"}, 64'(gid_v[d]), 0);
    chk({tag, "_perr"}, 64'(perr_v[d]), 0);
    chk({tag, "_terr"}, 64'(terr_v[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    m_address = '0; m_byteenable = '0; m_writedata = '0;
    m_read = '0; m_write = '0;

    apply_reset();
    chk_reset_vals("rst_fx", 0);
    chk_reset_vals("rst_rr", 1);

    // Single read through a slow slave.
    apply_reset();
    cur = 0; rd_delay = 2; sl_data = 32'hCAFE_F00D;
    push_cpl(0, 1'b1, 32'hCAFE_F00D);
    issue(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, '0);
    drain("t1", 50);
    repeat (3) tick();
    chk("t1_wlow_once", wlow[0], 1);
    chk("t1_latency", last_lat[0], 4);

    // Simultaneous writes under fixed priority.
    apply_reset();
    cur = 0; rd_delay = 1;
    push_cpl(0, 1'b0, '0);
    push_cpl(1, 1'b0, '0);
    push_wr(32'h0000_2000, 4'b1111, 32'h1111_1111);
    push_wr(32'h0000_2004, 4'b0011, 32'h2222_2222);
    issue(0, 1'b0, 1'b1, 32'h0000_2000, 4'b1111, 32'h1111_1111);
    issue(1, 1'b0, 1'b1, 32'h0000_2004, 4'b0011, 32'h2222_2222);
    drain("t2", 50);

    // Continuous reads from both masters under round robin alternate grants.
    apply_reset();
    cur = 1; sl_data = 32'h5A5A_0001;
    cont[0] = 2; cont[1] = 2;
    for (int k = 0; k < 6; k++) push_cpl(k % 2, 1'b1, 32'h5A5A_0001);
    issue(0, 1'b1, 1'b0, 32'h0000_3000, 4'hF, '0);
    issue(1, 1'b1, 1'b0, 32'h0000_3100, 4'hF, '0);
    drain("t3", 100);

    // Watchdog abort on a stuck slave, then normal service.
    apply_reset();
    cur = 0; stall = 1'b1; sl_data = 32'hFFFF_FFFF;
    push_cpl(0, 1'b1, '0);
    issue(0, 1'b1, 1'b0, 32'h0000_4000, 4'hF, '0);
    drain("t4", 60);
    chk("t4_latency", last_lat[0], TO + 1);
    chk("t4_terr", 64'(terr_v[0]), 1);
    repeat (5) tick();
    chk("t4_terr_sticky", 64'(terr_v[0]), 1);
    stall = 1'b0; sl_data = 32'h0BAD_BEEF;
    push_cpl(0, 1'b1, 32'h0BAD_BEEF);
    issue(0, 1'b1, 1'b0, 32'h0000_4004, 4'hF, '0);
    drain("t4b", 20);
    chk("t4b_latency", last_lat[0], 2);
    chk("t4b_terr", 64'(terr_v[0]), 1);

    // Granted master abandons its read mid-transfer.
    apply_reset();
    cur = 0; rd_delay = 5;
    chk("t5_perr_clean", 64'(perr_v[0]), 0);
    issue(1, 1'b1, 1'b0, 32'h0000_5000, 4'hF, '0);
    repeat (3) tick();
    chk("t5_busy_rd", 64'(s_rd_v[0]), 1);
    m_read[1] = 1'b0;
    #2;
    chk("t5_strobe_drop", 64'({s_rd_v[0], s_wr_v[0]}), 0);
    chk("t5_mwait_held", 64'(m_wait_v[0][1]), 1);
    repeat (2) tick();
    chk("t5_perr_abandon", 64'(perr_v[0]), 1);

    // Read and write together is served as a write.
    apply_reset();
    cur = 0;
    chk("t5b_perr_rst", 64'(perr_v[0]), 0);
    push_cpl(1, 1'b0, '0);
    push_wr(32'h0000_5100, 4'hF, 32'h3333_3333);
    issue(1, 1'b1, 1'b1, 32'h0000_5100, 4'hF, 32'h3333_3333);
    drain("t5b", 20);
    chk("t5b_perr_rw", 64'(perr_v[0]), 1);

    // Reset in the middle of a stalled write.
    apply_reset();
    cur = 0; stall = 1'b1;
    issue(1, 1'b0, 1'b1, 32'h0000_6000, 4'hF, 32'h4444_4444);
    repeat (3) tick();
    chk("t6_busy_wr", 64'(s_wr_v[0]), 1);
    chk("t6_gid_busy", 64'(gid_v[0]), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_gate", 64'({s_rd_v[0], s_wr_v[0]}), 0);
    repeat (2) tick();
    reset = 1'b0; m_write = '0; stall = 1'b0;
    #1;
    chk_reset_vals("t6_post", 0);
    tick();
    chk("t6_idle_mwait", 64'(m_wait_v[0]), 64'(2'b11));
    chk("t6_no_cpl", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
